// File: rtl/sum_xfer_tx_pkg.sv
// Shared sizing and lane helpers for the partial-sum transmit path.
// Imported by the interface, the queue and the top level.
package sum_xfer_tx_pkg;

  localparam int col     = 8;
  localparam int bw_psum = 20;
  localparam int depth   = 16;
  localparam int SUM_W   = bw_psum + 4;
  localparam int CNT_W   = $clog2(depth) + 1;

  typedef logic [SUM_W-1:0]       sum_t;
  typedef logic [bw_psum*col-1:0] row_t;

  function automatic logic signed [bw_psum-1:0] lane_of(input row_t v, input int k);
    return $signed(v[k*bw_psum +: bw_psum]);
  endfunction

endpackage

// File: rtl/sum_xfer_tx_if.sv
// Handshake bundle between the psum path / peer core and the transmit block.
interface sum_xfer_tx_if;
  import sum_xfer_tx_pkg::*;

  row_t psum_in;
  logic sum_wr;
  logic fifo_ext_rd;
  sum_t sum_out;
  logic sum_valid;
  logic full;
  logic empty;
  logic ovf;
  logic unf;

  modport slave (
    input  psum_in, sum_wr, fifo_ext_rd,
    output sum_out, sum_valid, full, empty, ovf, unf
  );

  modport master (
    output psum_in, sum_wr, fifo_ext_rd,
    input  sum_out, sum_valid, full, empty, ovf, unf
  );
endinterface

// File: rtl/sum_xfer_tx_fifo.sv
// Single-clock queue of reduced sums. A pop in the same edge frees the
// slot for a push when full; a push into an empty queue is never bypassed.
module sum_fifo
  import sum_xfer_tx_pkg::*;
#(
  parameter int DATA_W = SUM_W,
  parameter int DEPTH  = depth
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic              pop_ok_o,
  output logic              push_drop_o,
  output logic              pop_fail_o,
  output logic              full_o,
  output logic              empty_o
);

  localparam int ADDR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0] wptr_q, rptr_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              full_q, empty_q;
  logic              push_ok, pop_ok;

  assign pop_ok  = pop_i && !empty_q;
  assign push_ok = push_i && (!full_q || pop_ok);
  assign cnt_d   = cnt_q + CNT_W'(push_ok) - CNT_W'(pop_ok);

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      if (push_ok) wptr_q <= wptr_q + 1'b1;
      if (pop_ok)  rptr_q <= rptr_q + 1'b1;
      cnt_q   <= cnt_d;
      full_q  <= (cnt_d == CNT_W'(DEPTH));
      empty_q <= (cnt_d == '0);
    end
  end

  // Storage carries no reset; validity is tracked by the pointers alone.
  always_ff @(posedge clk) begin
    if (push_ok && !reset) mem_q[wptr_q] <= wdata_i;
  end

  assign rdata_o     = mem_q[rptr_q];
  assign pop_ok_o    = pop_ok;
  assign push_drop_o = push_i && !push_ok;
  assign pop_fail_o  = pop_i && empty_q;
  assign full_o      = full_q;
  assign empty_o     = empty_q;

endmodule

// File: rtl/sum_xfer_tx.sv
// Reduces a row of signed psums to one sum of magnitudes, queues it, and
// presents popped entries to the peer core on sum_out.
module sum_xfer_tx
  import sum_xfer_tx_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  sum_xfer_tx_if.slave  bus
);

  sum_t sum_d;
  sum_t sum_p1_q;
  logic vld_p1_q;
  sum_t sum_out_q;
  logic sum_valid_q;
  logic ovf_q, unf_q;

  sum_t fifo_rdata;
  logic pop_ok, push_drop, pop_fail;
  logic fifo_full, fifo_empty;

  // Magnitude of the most negative lane is 2^(bw_psum-1), which still fits unsigned.
  function automatic logic [bw_psum-1:0] abs_mag(input logic signed [bw_psum-1:0] x);
    logic signed [bw_psum:0] e;
    e = x;
    return x[bw_psum-1] ? bw_psum'(-e) : bw_psum'(e);
  endfunction

  always_comb begin
    sum_d = '0;
    for (int k = 0; k < col; k++) begin
      sum_d = sum_d + SUM_W'(abs_mag(lane_of(bus.psum_in, k)));
    end
  end

  // Stage 1: registered reduction
  always_ff @(posedge clk) begin
    if (reset) begin
      sum_p1_q <= '0;
      vld_p1_q <= 1'b0;
    end else begin
      vld_p1_q <= bus.sum_wr;
      if (bus.sum_wr) sum_p1_q <= sum_d;
    end
  end

  // Stage 2: enqueue; pops are served from the queue head
  sum_fifo #(
    .DATA_W (SUM_W),
    .DEPTH  (depth)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (vld_p1_q),
    .wdata_i     (sum_p1_q),
    .pop_i       (bus.fifo_ext_rd),
    .rdata_o     (fifo_rdata),
    .pop_ok_o    (pop_ok),
    .push_drop_o (push_drop),
    .pop_fail_o  (pop_fail),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  // Output register and sticky error flags
  always_ff @(posedge clk) begin
    if (reset) begin
      sum_out_q   <= '0;
      sum_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
    end else begin
      sum_valid_q <= pop_ok;
      if (pop_ok) sum_out_q <= fifo_rdata;
      ovf_q <= ovf_q | push_drop;
      unf_q <= unf_q | pop_fail;
    end
  end

  assign bus.sum_out   = sum_out_q;
  assign bus.sum_valid = sum_valid_q;
  assign bus.full      = fifo_full;
  assign bus.empty     = fifo_empty;
  assign bus.ovf       = ovf_q;
  assign bus.unf       = unf_q;

endmodule

// File: tb/tb_sum_xfer_tx.sv
// Directed and randomized bench for sum_xfer_tx against a queue-based reference.
module tb_sum_xfer_tx;
  import sum_xfer_tx_pkg::*;

  logic clk = 1'b0;
  logic reset;
  sum_xfer_tx_if bus ();

  sum_xfer_tx dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  int lanes [col];
  int q [$];
  bit pend_v;
  longint pend_s;
  longint m_out;
  bit m_valid, m_ovf, m_unf;

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic longint ref_sum();
    longint s = 0;
    for (int k = 0; k < col; k++) s += (lanes[k] < 0) ? -lanes[k] : lanes[k];
    return s;
  endfunction

  task automatic drive_lanes();
    row_t p;
    int v;
    p = '0;
    for (int k = 0; k < col; k++) begin
      v = lanes[k];
      p[k*bw_psum +: bw_psum] = v[bw_psum-1:0];
    end
    bus.psum_in = p;
  endtask

  task automatic set_lanes_zero();
    for (int k = 0; k < col; k++) lanes[k] = 0;
    drive_lanes();
  endtask

  // One clock edge: drive, update reference, compare every output.
  task automatic step(input bit wr, input bit rd, input bit rst);
    bit pop_ok;
    bus.sum_wr = wr;
    bus.fifo_ext_rd = rd;
    reset = rst;
    @(posedge clk);
    if (rst) begin
      q.delete();
      pend_v = 0; pend_s = 0; m_out = 0;
      m_valid = 0; m_ovf = 0; m_unf = 0;
    end else begin
      pop_ok = rd && (q.size() > 0);
      if (rd && !pop_ok) m_unf = 1;
      if (pop_ok) m_out = q.pop_front();
      m_valid = pop_ok;
      if (pend_v) begin
        if (q.size() < depth) q.push_back(int'(pend_s));
        else m_ovf = 1;
      end
      pend_v = wr;
      pend_s = ref_sum();
    end
    #1;
    chk("sum_out",   longint'(bus.sum_out), m_out);
    chk("sum_valid", longint'(bus.sum_valid), longint'(m_valid));
    chk("full",      longint'(bus.full), longint'(q.size() == depth));
    chk("empty",     longint'(bus.empty), longint'(q.size() == 0));
    chk("ovf",       longint'(bus.ovf), longint'(m_ovf));
    chk("unf",       longint'(bus.unf), longint'(m_unf));
  endtask

  initial begin
    bus.sum_wr = 0; bus.fifo_ext_rd = 0; reset = 1;
    set_lanes_zero();

    // 1 reset
    step(0, 0, 1); step(1, 1, 1);
    chk("rst_sum_out", longint'(bus.sum_out), 0);
    chk("rst_empty",   longint'(bus.empty), 1);
    chk("rst_full",    longint'(bus.full), 0);

    // 2 reduce
    lanes = '{1, -2, 3, -4, 5, -6, 7, -8}; drive_lanes();
    step(1, 0, 0); set_lanes_zero();
    step(0, 0, 0);
    step(0, 1, 0);
    chk("reduce_val",   longint'(bus.sum_out), 36);
    chk("reduce_vld",   longint'(bus.sum_valid), 1);
    step(0, 0, 0);
    chk("reduce_pulse", longint'(bus.sum_valid), 0);

    // 3 extreme lanes
    for (int k = 0; k < col; k++) lanes[k] = -(1 << 19);
    drive_lanes();
    step(1, 0, 0); set_lanes_zero();
    step(0, 0, 0); step(0, 1, 0);
    chk("extreme_val", longint'(bus.sum_out), 4194304);

    // 4 fill past capacity
    for (int v = 1; v <= 17; v++) begin
      set_lanes_zero(); lanes[0] = v; drive_lanes();
      step(1, 0, 0);
    end
    set_lanes_zero();
    chk("full_after16", longint'(bus.full), 1);
    step(0, 0, 0);
    chk("ovf_set", longint'(bus.ovf), 1);
    for (int i = 1; i <= 16; i++) begin
      step(0, 1, 0);
      chk("drain_order", longint'(bus.sum_out), i);
    end

    // 5 empty pop, then push+pop while empty
    step(0, 1, 0);
    chk("empty_pop_vld", longint'(bus.sum_valid), 0);
    chk("empty_pop_hold", longint'(bus.sum_out), 16);
    chk("empty_pop_unf", longint'(bus.unf), 1);
    step(0, 0, 1);
    lanes[2] = -77; drive_lanes();
    step(1, 0, 0); set_lanes_zero();
    step(0, 1, 0);
    chk("pushpop_empty_unf",   longint'(bus.unf), 1);
    chk("pushpop_empty_empty", longint'(bus.empty), 0);
    step(0, 1, 0);
    chk("pushpop_empty_val", longint'(bus.sum_out), 77);

    // 6 reset mid-operation
    step(0, 0, 1);
    for (int i = 0; i < 5; i++) begin
      lanes[0] = 100 + i; drive_lanes();
      step(1, 0, 0);
    end
    set_lanes_zero();
    step(0, 0, 0);
    step(0, 0, 1);
    chk("midrst_empty", longint'(bus.empty), 1);
    step(0, 1, 0);
    chk("midrst_unf", longint'(bus.unf), 1);
    chk("midrst_vld", longint'(bus.sum_valid), 0);
    chk("midrst_out", longint'(bus.sum_out), 0);

    // randomized traffic
    step(0, 0, 1);
    for (int n = 0; n < 600; n++) begin
      for (int k = 0; k < col; k++)
        lanes[k] = int'($urandom_range(0, (1 << bw_psum) - 1)) - (1 << (bw_psum - 1));
      drive_lanes();
      step(bit'($urandom_range(0, 99) < 60), bit'($urandom_range(0, 99) < (n < 300 ? 35 : 65)),
           bit'($urandom_range(0, 149) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
